// File: rtl/rr_mux_sel_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_sel_pkg
// Description : Shared types, constants and helpers for the round-robin
//               select arbiter that drives a 4x1 mux select.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_mux_sel_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] sel_t;
    typedef logic [3:0] req_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // One-hot grant vector for a channel index
    function automatic req_t onehot(input sel_t s);
        return req_t'(1) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_mux_sel_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick_next
// Description : Combinational rotate-priority encoder. Searches req starting
//               one past 'last' and wrapping, so 'last' has lowest priority.
//               With RR_MUX_SEL_FIXED_PRIO_EN defined, channel 0 is always
//               highest priority and 'last' is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick_next
    import rr_mux_sel_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    assign any = |req;

`ifdef RR_MUX_SEL_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = ^last;

    // Lowest-numbered requester wins; scanning downward lets it overwrite
    always_comb begin
        pick = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick = sel_t'(k);
            end
        end
    end
`else
    sel_t w_idx;

    // Scan offsets from farthest to nearest so the nearest requester after
    // 'last' is the final assignment; offset NUM_CH wraps back onto 'last'
    always_comb begin
        pick  = '0;
        w_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = last + sel_t'(k);
            if (req[w_idx]) begin
                pick = w_idx;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_sel_arbiter
// Description : Four-channel round-robin arbiter producing the select for a
//               downstream 4x1 mux. A grant lasts until the owner drops its
//               request or MAX_BEATS accepted beats, then rotates with no
//               bubble. All outputs come straight from registers.
//               Optional macro RR_MUX_SEL_FIXED_PRIO_EN selects fixed
//               priority (ch0 highest) instead of round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_sel_arbiter
    import rr_mux_sel_pkg::*;
#(
    parameter int MAX_BEATS = 4
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       sel_ready,
    output logic [1:0] sel_mux,
    output logic       sel_valid,
    output logic [3:0] grant
);

    localparam int               CNT_W       = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t           state_q, state_d;
    sel_t             sel_q, sel_d;
    logic             valid_q, valid_d;
    req_t             grant_q, grant_d;
    sel_t             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sel_t             w_pick;
    logic             w_any;
    logic             w_beat;
    logic             w_end;

    // last_q equals the current owner while granted, so the same pointer
    // serves both first arbitration from IDLE and re-arbitration at a boundary
    rr_pick_next u_pick (
        .req  (req),
        .last (last_q),
        .pick (w_pick),
        .any  (w_any)
    );

    assign w_beat = valid_q & sel_ready;
    assign w_end  = !req[sel_q] || (w_beat && (cnt_q == C_LAST_BEAT));

    // Next-state: arbitrate from IDLE, count beats and hand over at grant end
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d = GRANT;
                    sel_d   = w_pick;
                    valid_d = 1'b1;
                    grant_d = onehot(w_pick);
                    last_d  = w_pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (w_beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (w_end) begin
                    if (w_any) begin
                        sel_d   = w_pick;
                        grant_d = onehot(w_pick);
                        last_d  = w_pick;
                        cnt_d   = '0;
                    end else begin
                        // sel_mux deliberately keeps its last value when idle
                        state_d = IDLE;
                        valid_d = 1'b0;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset makes channel 0 first in line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel_mux   = sel_q;
    assign sel_valid = valid_q;
    assign grant     = grant_q;

endmodule
`default_nettype wire

// File: doc/rr_mux_sel_arbiter.md
Name: rr_mux_sel_arbiter

Overview:
- Four-channel round-robin arbiter that sits directly upstream of mux_4_by_1_case.
- Drives the mux's 2-bit sel_mux from four request lines.
- Holds a grant for a bounded number of accepted beats, so one channel's bit stream is routed through the mux at a time, with fair rotation between channels.

Parameters:
- MAX_BEATS, 4: maximum accepted beats per grant before forced rotation. Legal range is 1..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- req  input  4  per-channel request; bit i corresponds to in_mux_(i+1).
- sel_ready  input  1  downstream consumer accepts the current mux output this cycle.
- sel_mux  output  2  select index for the 4x1 mux, encoded 0..3.
- sel_valid  output  1  sel_mux is valid and a grant is active.
- grant  output  4  one-hot active grant; all zero when idle.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at posedge):
  - state=IDLE; sel_mux=2'b00; sel_valid=0; grant=4'b0000; beat_cnt=0.
  - Last-grant pointer last=3, so channel 0 has first priority.
  - A reset asserted mid-grant aborts the grant immediately. No beat is counted in that cycle.
- All outputs are registered and driven straight from state/grant registers, with no combinational path from inputs to outputs.
- Pick function: first set bit of req, searching (last+1)%4, (last+2)%4, (last+3)%4, last.
- IDLE state:
  - If req!=0, load grant=onehot(pick), sel_mux=pick, sel_valid=1, last=pick, beat_cnt=0, go to GRANT.
  - Latency: 1 cycle from req sampled to sel_valid=1.
  - If req==0, remain in IDLE.
- GRANT state:
  - Beat: sel_valid & sel_ready in a cycle; beat_cnt increments (width $clog2(MAX_BEATS+1)).
  - Termination condition end = !req[sel_mux] OR (beat && beat_cnt==MAX_BEATS-1).
  - If end and any other req is set: re-arbitrate in the same cycle via pick, with the current owner lowest priority. The new grant appears next cycle with no bubble, and beat_cnt=0.
  - If end and the only request left is the current owner (quota exhausted, req still high): re-grant the same channel and reset beat_cnt=0.
  - If end and req==0: go to IDLE with sel_valid=0 and grant=0. sel_mux holds its last value.
  - If not end: hold all outputs.
  - A beat in the same cycle that the owner's req drops is still counted, but does not matter since the grant ends anyway.
- Stability: sel_mux and grant never change while sel_valid=1 except at a grant boundary.
- Invariants: grant is always one-hot or zero, and grant==0 iff sel_valid==0.
- MAX_BEATS=1: rotates after every accepted beat.

Optional Feature:
- Macro RR_MUX_SEL_FIXED_PRIO_EN.
- Defined: fixed priority, channel 0 highest and channel 3 lowest. The last pointer is ignored for picking, and MAX_BEATS quota termination still applies. On quota expiry, the highest-priority requester is picked, which may be the same channel.
- Undefined: round-robin as specified above.

Decomposition:
- Package rr_mux_sel_pkg:
  - NUM_CH=4.
  - typedef logic [1:0] sel_t.
  - typedef logic [3:0] req_t.
  - enum state_t {IDLE, GRANT}.
  - Function onehot(sel_t).
- Sub-module rr_pick_next: combinational rotate-priority encoder.
  - Inputs: req, last.
  - Outputs: pick, any.
  - Contains the fixed-priority variant under the macro.
- Top holds the FSM, beat counter and output registers, and instantiates one rr_pick_next.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> sel_valid=0, grant=0, sel_mux=0. Release, then the first grant is ch0 (sel_mux=0, grant=4'b0001) one cycle later.
- Rotation: req=4'b1111, sel_ready=1, MAX_BEATS=4 -> grant sequence 0,1,2,3,0, each lasting exactly 4 cycles, with no sel_valid gap.
- Release: ch2 only (req=4'b0100), sel_ready=0. Drop req[2] after 3 cycles -> sel_valid=0 next cycle, IDLE, last=2. Then req=4'b0101 -> ch0 granted (search order 3,0).
- Backpressure: req=4'b0011, sel_ready toggling 1,0,1,0 -> ch0 holds for 8 cycles (4 beats), then ch1. sel_mux stable throughout.
- Reset mid-grant: ch1 granted after 2 beats, rst_n=0 for 1 cycle -> outputs zero next cycle. After release with req=4'b0010 -> ch1 re-granted with a full quota of 4.
- Macro defined: req=4'b1010 with quota expiry -> ch1 is re-granted repeatedly and ch3 is never granted.
